// File: rtl/cic_pkg.sv
// cic_pkg: shared constants and width helpers for the CIC decimator.
//   clog2   - ceiling log2 used to size the rate port
//   cic_ow  - full-precision CIC width: IW + N * clog2(RMAX)
//   N_MIN/N_MAX - legal range of the stage count
package cic_pkg;

  localparam int unsigned N_MIN = 1;
  localparam int unsigned N_MAX = 6;

  // Ceiling log2; returns 0 for inputs of 0 or 1.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    int unsigned rem;
    result = 0;
    rem    = (value > 0) ? value - 1 : 0;
    for (int i = 0; i < 32; i++) begin
      if (rem != 0) begin
        result = result + 1;
        rem    = rem >> 1;
      end
    end
    return result;
  endfunction

  // Output width that holds R^N gain for any R up to rmax without overflow.
  function automatic int unsigned cic_ow(input int unsigned iw,
                                         input int unsigned n,
                                         input int unsigned rmax);
    return iw + n * clog2(rmax);
  endfunction

endpackage

// File: rtl/cic_integrator_stage.sv
// cic_integrator_stage: one clock-enabled, wrapping accumulator of the
// CIC integrator cascade.
//   clk_i   - clock
//   reset_i - synchronous active-high reset, clears the accumulator
//   ce_i    - accumulate enable
//   x_i     - addend (previous stage's registered value or input sample)
//   acc_o   - registered accumulator value
module cic_integrator_stage #(
  parameter int unsigned W = 17
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         ce_i,
  input  logic [W-1:0] x_i,
  output logic [W-1:0] acc_o
);

  logic [W-1:0] acc_q;
  logic [W-1:0] acc_d;

  // Modulo-2^W add; wrap is cancelled later by the combs.
  always_comb begin
    acc_d = acc_q;
    if (ce_i) begin
      acc_d = acc_q + x_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/cic_decimator.sv
// cic_decimator: N-stage CIC decimator with runtime ratio R = i_rate + 1.
//   i_clk    - clock
//   i_reset  - synchronous active-high reset
//   i_ce     - input sample valid
//   i_data   - signed input sample (IW bits)
//   i_rate   - decimation ratio minus one; applied at period boundaries
//   o_data   - signed full-precision output (OW bits), held between strobes
//   o_valid  - one-cycle strobe marking a new o_data
module cic_decimator
  import cic_pkg::*;
#(
  parameter  int unsigned IW   = 5,
  parameter  int unsigned N    = 3,
  parameter  int unsigned RMAX = 16,
  localparam int unsigned RW   = clog2(RMAX),
  localparam int unsigned OW   = cic_ow(IW, N, RMAX)
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_ce,
  input  logic [IW-1:0] i_data,
  input  logic [RW-1:0] i_rate,
  output logic [OW-1:0] o_data,
  output logic          o_valid
);

  // ---------------------------------------------------------------
  // Integrator cascade
  // ---------------------------------------------------------------
  logic [OW-1:0] data_ext;
  logic [OW-1:0] int_acc [N];

  assign data_ext = OW'($signed(i_data));

  for (genvar g = 0; g < N; g++) begin : g_int
    logic [OW-1:0] stage_in;
    if (g == 0) begin : g_first
      assign stage_in = data_ext;
    end else begin : g_rest
      assign stage_in = int_acc[g-1];
    end

    cic_integrator_stage #(
      .W (OW)
    ) u_int (
      .clk_i   (i_clk),
      .reset_i (i_reset),
      .ce_i    (i_ce),
      .x_i     (stage_in),
      .acc_o   (int_acc[g])
    );
  end

  // ---------------------------------------------------------------
  // Decimation counter and rate register
  // ---------------------------------------------------------------
  logic [RW-1:0] count_q, count_d;
  logic [RW-1:0] rate_q,  rate_d;
  logic [OW-1:0] dec_q,   dec_d;
  logic          dec_v_q, dec_v_d;

  // Last i_ce of a period samples the pre-update integrator output and
  // picks up the new ratio, so a rate change never truncates a period.
  always_comb begin
    count_d = count_q;
    rate_d  = rate_q;
    dec_d   = dec_q;
    dec_v_d = 1'b0;
    if (i_ce) begin
      if (count_q == rate_q) begin
        count_d = '0;
        rate_d  = i_rate;
        dec_d   = int_acc[N-1];
        dec_v_d = 1'b1;
      end else begin
        count_d = count_q + RW'(1);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      count_q <= '0;
      rate_q  <= i_rate;
      dec_q   <= '0;
      dec_v_q <= 1'b0;
    end else begin
      count_q <= count_d;
      rate_q  <= rate_d;
      dec_q   <= dec_d;
      dec_v_q <= dec_v_d;
    end
  end

  // ---------------------------------------------------------------
  // Comb cascade: one stage per clock, driven by the valid pipeline
  // ---------------------------------------------------------------
  logic [OW-1:0] comb_y [N];
  logic          comb_v [N];

  for (genvar g = 0; g < N; g++) begin : g_comb
    logic [OW-1:0] x_in;
    logic          v_in;
    logic [OW-1:0] y_q, y_d;
    logic [OW-1:0] dly_q, dly_d;
    logic          v_q;

    if (g == 0) begin : g_first
      assign x_in = dec_q;
      assign v_in = dec_v_q;
    end else begin : g_rest
      assign x_in = comb_y[g-1];
      assign v_in = comb_v[g-1];
    end

    // Differential delay of one decimated sample.
    always_comb begin
      y_d   = y_q;
      dly_d = dly_q;
      if (v_in) begin
        y_d   = x_in - dly_q;
        dly_d = x_in;
      end
    end

    always_ff @(posedge i_clk) begin
      if (i_reset) begin
        y_q   <= '0;
        dly_q <= '0;
        v_q   <= 1'b0;
      end else begin
        y_q   <= y_d;
        dly_q <= dly_d;
        v_q   <= v_in;
      end
    end

    assign comb_y[g] = y_q;
    assign comb_v[g] = v_q;
  end

  assign o_data  = comb_y[N-1];
  assign o_valid = comb_v[N-1];

endmodule
